fifo_rr_pick_arb: RTL and testbench

Credit-gated, round-robin read scheduler for a bank of `REQ_NUM` overwrite-capable one-in-one-out FIFOs. Upstream, it gates each producer's write with a per-FIFO credit counter so that no FIFO entry is ever overwritten. Downstream, it picks one non-empty FIFO per cycle in round-robin order and drains it into a single registered valid/ready output stage. It sits between the per-lane FIFOs and the shared consumer, and supplies the qualify logic that those FIFOs require.

---
 rtl/fifo_rr_pick_arb.sv | 158 +++++++++++++++
 tb/tb_fifo_rr_pick_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_pick_arb.sv
//------------------------------------------------------------------------------
// fifo_rr_pick_arb
//
// Credit-gated round-robin read scheduler for a bank of REQ_NUM one-in-one-out
// FIFOs. On the write side every FIFO has a credit counter. A producer write
// is only passed on to its FIFO while a credit is left, so an entry is never
// overwritten. On the read side one non-empty FIFO per cycle is picked in
// round-robin order. Its head entry is moved into a single registered
// valid/ready output stage.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_up_vld         per-FIFO producer write request
//   o_up_rdy         per-FIFO credit available (credit counter non-zero)
//   o_fifo_in_vld    per-FIFO qualified write (i_up_vld & o_up_rdy)
//   i_fifo_out_vld   per-FIFO non-empty flag (registered inside the FIFO)
//   i_fifo_out_data  per-FIFO head data, FIFO i at [i*DATA_SIZE +: DATA_SIZE]
//   o_fifo_pick_rdy  one-hot pop of the winning FIFO, all-zero when idle
//   o_dn_vld         output stage holds valid data
//   o_dn_data        output payload
//   o_dn_src         index of the FIFO that supplied o_dn_data
//   i_dn_rdy         consumer accepts the output stage this cycle
//------------------------------------------------------------------------------
module fifo_rr_pick_arb #(
   parameter int REQ_NUM   = 4,
   parameter int ENT_NUM   = 4,
   parameter int DATA_SIZE = 32,
   parameter int REQ_W     = $clog2(REQ_NUM),
   parameter int CRD_W     = $clog2(ENT_NUM + 1)
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [REQ_NUM-1:0]           i_up_vld,
   output logic [REQ_NUM-1:0]           o_up_rdy,
   output logic [REQ_NUM-1:0]           o_fifo_in_vld,
   input  logic [REQ_NUM-1:0]           i_fifo_out_vld,
   input  logic [REQ_NUM*DATA_SIZE-1:0] i_fifo_out_data,
   output logic [REQ_NUM-1:0]           o_fifo_pick_rdy,
   output logic                         o_dn_vld,
   output logic [DATA_SIZE-1:0]         o_dn_data,
   output logic [REQ_W-1:0]             o_dn_src,
   input  logic                         i_dn_rdy
);

   localparam logic [CRD_W-1:0]   CRD_RST  = CRD_W'(ENT_NUM);
   localparam logic [CRD_W-1:0]   CRD_ONE  = CRD_W'(1'b1);
   localparam logic [REQ_NUM-1:0] PRIO_RST = REQ_NUM'(1'b1);

   logic [CRD_W-1:0]     r_crd [REQ_NUM];
   logic [REQ_NUM-1:0]   r_prio;
   logic                 r_dn_vld;
   logic [DATA_SIZE-1:0] r_dn_data;
   logic [REQ_W-1:0]     r_dn_src;

   logic [REQ_NUM-1:0]   w_up_rdy;
   logic [REQ_NUM-1:0]   w_in_vld;
   logic [2*REQ_NUM-1:0] w_req_dbl;
   logic [2*REQ_NUM-1:0] w_gnt_dbl;
   logic [REQ_NUM-1:0]   w_win_oh;
   logic [REQ_W-1:0]     w_win_idx;
   logic [DATA_SIZE-1:0] w_win_data;
   logic                 w_load;
   logic [REQ_NUM-1:0]   w_pick;
   logic                 w_pop;

   // A FIFO may take a write while at least one credit is left; this depends
   // only on the credit registers, so there is no path from i_dn_rdy to it.
   always_comb begin
      w_up_rdy = {REQ_NUM{1'b0}};
      for (int i = 0; i < REQ_NUM; i++) begin
         w_up_rdy[i] = (r_crd[i] != {CRD_W{1'b0}});
      end
   end

   assign w_in_vld = i_up_vld & w_up_rdy;

   // Round-robin winner: the request vector is doubled so that the search
   // starting at r_prio can wrap. Subtracting the one-hot pointer and masking
   // leaves exactly the first set request at or above the pointer.
   always_comb begin
      w_req_dbl = {i_fifo_out_vld, i_fifo_out_vld};
      w_gnt_dbl = w_req_dbl & ~(w_req_dbl - {{REQ_NUM{1'b0}}, r_prio});
      w_win_oh  = w_gnt_dbl[2*REQ_NUM-1:REQ_NUM] | w_gnt_dbl[REQ_NUM-1:0];
   end

   // Encode the one-hot winner into an index and select its head data.
   always_comb begin
      w_win_idx  = {REQ_W{1'b0}};
      w_win_data = {DATA_SIZE{1'b0}};
      for (int i = 0; i < REQ_NUM; i++) begin
         w_win_idx  = w_win_idx | (REQ_W'(i) & {REQ_W{w_win_oh[i]}});
         w_win_data = w_win_data |
                      (i_fifo_out_data[i*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{w_win_oh[i]}});
      end
   end

   // The output stage can take a new entry when it is empty or being drained.
   assign w_load = ~r_dn_vld | i_dn_rdy;
   assign w_pick = w_win_oh & {REQ_NUM{w_load}};
   assign w_pop  = |w_pick;

   // Credit counters: a write consumes a credit and a pop returns one.
   // A write and a pop in the same cycle cancel out.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < REQ_NUM; i++) begin
            r_crd[i] <= CRD_RST;
         end
      end else begin
         for (int i = 0; i < REQ_NUM; i++) begin
            case ({w_in_vld[i], w_pick[i]})
               2'b10:   r_crd[i] <= r_crd[i] - CRD_ONE;
               2'b01:   r_crd[i] <= r_crd[i] + CRD_ONE;
               default: r_crd[i] <= r_crd[i];
            endcase
         end
      end
   end

   // Priority pointer: after a pop it moves to the FIFO just past the winner
   // (a one-bit rotate of the winner). Otherwise it holds.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prio <= PRIO_RST;
      end else if (w_pop) begin
         r_prio <= {w_win_oh[REQ_NUM-2:0], w_win_oh[REQ_NUM-1]};
      end else begin
         r_prio <= r_prio;
      end
   end

   // Output stage: load on a pop, clear on a drain with no refill, hold
   // otherwise. This keeps data and source stable while stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dn_vld  <= 1'b0;
         r_dn_data <= {DATA_SIZE{1'b0}};
         r_dn_src  <= {REQ_W{1'b0}};
      end else if (w_pop) begin
         r_dn_vld  <= 1'b1;
         r_dn_data <= w_win_data;
         r_dn_src  <= w_win_idx;
      end else if (i_dn_rdy) begin
         r_dn_vld  <= 1'b0;
      end else begin
         r_dn_vld  <= r_dn_vld;
      end
   end

   assign o_up_rdy        = w_up_rdy;
   assign o_fifo_in_vld   = w_in_vld;
   assign o_fifo_pick_rdy = w_pick;
   assign o_dn_vld        = r_dn_vld;
   assign o_dn_data       = r_dn_data;
   assign o_dn_src        = r_dn_src;

endmodule

// File: tb/tb_fifo_rr_pick_arb.sv
//------------------------------------------------------------------------------
// tb_fifo_rr_pick_arb
//
// Bench for fifo_rr_pick_arb. It contains a behavioural model of the four
// attached FIFOs, depth 4 each, with a registered non-empty flag. Producer
// data that is expected to reach the consumer goes into a scoreboard queue in
// consumer order, and is compared whenever the output stage hands over.
//------------------------------------------------------------------------------
module tb_fifo_rr_pick_arb;

   localparam int REQ_NUM   = 4;
   localparam int ENT_NUM   = 4;
   localparam int DATA_SIZE = 32;
   localparam int REQ_W     = 2;

   logic                         clk = 1'b0;
   logic                         rst_n = 1'b0;
   logic [REQ_NUM-1:0]           up_vld;
   logic [REQ_NUM-1:0]           up_rdy;
   logic [REQ_NUM-1:0]           fifo_in_vld;
   logic [REQ_NUM-1:0]           fifo_out_vld;
   logic [REQ_NUM*DATA_SIZE-1:0] fifo_out_data;
   logic [REQ_NUM-1:0]           fifo_pick_rdy;
   logic                         dn_vld;
   logic [DATA_SIZE-1:0]         dn_data;
   logic [REQ_W-1:0]             dn_src;
   logic                         dn_rdy;

   logic [DATA_SIZE-1:0] wr_data [REQ_NUM];
   logic [DATA_SIZE-1:0] mem [REQ_NUM][ENT_NUM];
   logic [1:0]           wp [REQ_NUM];
   logic [1:0]           rp [REQ_NUM];
   logic [2:0]           cnt [REQ_NUM];
   int                   viol = 0;

   int                   n_chk = 0;
   int                   n_pass = 0;
   logic [33:0]          sb_q [$];

   fifo_rr_pick_arb #(.REQ_NUM(REQ_NUM), .ENT_NUM(ENT_NUM), .DATA_SIZE(DATA_SIZE)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_up_vld(up_vld), .o_up_rdy(up_rdy),
      .o_fifo_in_vld(fifo_in_vld), .i_fifo_out_vld(fifo_out_vld),
      .i_fifo_out_data(fifo_out_data), .o_fifo_pick_rdy(fifo_pick_rdy),
      .o_dn_vld(dn_vld), .o_dn_data(dn_data), .o_dn_src(dn_src), .i_dn_rdy(dn_rdy)
   );

   always #5 clk = ~clk;

   // Attached FIFO model plus invariant monitor. The monitor flags: a write
   // into a full FIFO, a pop from an empty one, more than one pop per cycle,
   // and credit + occupancy differing from the depth. The last one catches
   // credit underflow and credit overflow.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REQ_NUM; i++) begin
            wp[i] <= 2'd0; rp[i] <= 2'd0; cnt[i] <= 3'd0;
         end
      end else begin
         for (int i = 0; i < REQ_NUM; i++) begin
            if (fifo_in_vld[i]) begin
               mem[i][wp[i]] <= wr_data[i];
               wp[i] <= wp[i] + 2'd1;
            end
            if (fifo_pick_rdy[i]) rp[i] <= rp[i] + 2'd1;
            cnt[i] <= cnt[i] + {2'b00, fifo_in_vld[i]} - {2'b00, fifo_pick_rdy[i]};
            if (fifo_in_vld[i] && !fifo_pick_rdy[i] && cnt[i] == 3'd4) viol <= viol + 1;
            if (fifo_pick_rdy[i] && cnt[i] == 3'd0) viol <= viol + 1;
            if (int'(dut.r_crd[i]) + int'(cnt[i]) != ENT_NUM) viol <= viol + 1;
         end
         if ($countones(fifo_pick_rdy) > 1) viol <= viol + 1;
      end
   end

   always_comb begin
      for (int i = 0; i < REQ_NUM; i++) begin
         fifo_out_vld[i] = (cnt[i] != 3'd0);
         fifo_out_data[i*DATA_SIZE +: DATA_SIZE] = mem[i][rp[i]];
      end
   end

   // Advance to 3 time units after the next rising edge: the point where inputs are driven.
   task automatic cyc();
      @(posedge clk);
      #3;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; up_vld = 4'b0000; dn_rdy = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) wr_data[i] = 32'h0;
      sb_q.delete();
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; up_vld = 4'b0000; dn_rdy = 1'b0;
      repeat (2) cyc();
      #1;
      n_chk++; if (up_rdy !== 4'b1111) $display("FAIL reset_up_rdy: got %b expected 1111", up_rdy); else n_pass++;
      n_chk++; if (dn_vld !== 1'b0) $display("FAIL reset_dn_vld: got %b expected 0", dn_vld); else n_pass++;
      n_chk++; if (fifo_pick_rdy !== 4'b0000) $display("FAIL reset_pick: got %b expected 0000", fifo_pick_rdy); else n_pass++;
      n_chk++; if (dn_data !== 32'h0) $display("FAIL reset_dn_data: got %h expected 0", dn_data); else n_pass++;
      n_chk++; if (dn_src !== 2'd0) $display("FAIL reset_dn_src: got %0d expected 0", dn_src); else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      cyc(); up_vld = 4'b0100; wr_data[2] = 32'h0000_00A5; dn_rdy = 1'b1; #1;
      n_chk++; if (fifo_in_vld !== 4'b0100) $display("FAIL single_in_vld: got %b expected 0100", fifo_in_vld); else n_pass++;
      cyc(); up_vld = 4'b0000; #1;
      n_chk++; if (fifo_pick_rdy !== 4'b0100) $display("FAIL single_pick: got %b expected 0100", fifo_pick_rdy); else n_pass++;
      n_chk++; if (dn_vld !== 1'b0) $display("FAIL single_early_vld: got %b expected 0", dn_vld); else n_pass++;
      cyc(); #1;
      n_chk++; if (dn_vld !== 1'b1) $display("FAIL single_dn_vld: got %b expected 1", dn_vld); else n_pass++;
      n_chk++; if (dn_data !== 32'h0000_00A5) $display("FAIL single_dn_data: got %h expected 000000a5", dn_data); else n_pass++;
      n_chk++; if (dn_src !== 2'd2) $display("FAIL single_dn_src: got %0d expected 2", dn_src); else n_pass++;
      cyc(); #1;
      n_chk++; if (dn_vld !== 1'b0) $display("FAIL single_drained: got %b expected 0", dn_vld); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [33:0] exp;
      int got, first, last;
      got = 0; first = -1; last = -1;
      apply_reset(); dn_rdy = 1'b1;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (c < 4) begin
            up_vld = 4'b1111;
            for (int i = 0; i < REQ_NUM; i++) begin
               wr_data[i] = 32'h1000_0000 + 32'(i * 256 + c);
               sb_q.push_back({REQ_W'(i), wr_data[i]});
            end
         end else begin
            up_vld = 4'b0000;
         end
         #1;
         if (dn_vld && dn_rdy) begin
            n_chk++; got++; if (first < 0) first = c; last = c;
            if (sb_q.size() == 0) $display("FAIL rr_sb: unexpected src=%0d data=%h", dn_src, dn_data);
            else begin
               exp = sb_q.pop_front();
               if ({dn_src, dn_data} !== exp)
                  $display("FAIL rr_sb: got src=%0d data=%h expected src=%0d data=%h", dn_src, dn_data, exp[33:32], exp[31:0]);
               else n_pass++;
            end
         end
      end
      n_chk++; if (got !== 16) $display("FAIL rr_count: got %0d expected 16", got); else n_pass++;
      n_chk++; if (last - first !== 15) $display("FAIL rr_throughput: got span %0d expected 15", last - first); else n_pass++;
   endtask

   task automatic test_credit_exhaust();
      logic [33:0] exp;
      logic        e_rdy;
      apply_reset(); dn_rdy = 1'b0;
      cyc(); up_vld = 4'b0001; wr_data[0] = 32'h0000_0C00; sb_q.push_back({2'd0, 32'h0000_0C00}); #1;
      cyc(); up_vld = 4'b0000; #1;
      cyc();
      for (int n = 0; n < 5; n++) begin
         up_vld = 4'b0010; wr_data[1] = 32'h0000_0100 + 32'(n); #1;
         e_rdy = (n < 4);
         n_chk++; if (up_rdy[1] !== e_rdy) $display("FAIL crd_up_rdy[%0d]: got %b expected %b", n, up_rdy[1], e_rdy); else n_pass++;
         n_chk++; if (fifo_in_vld[1] !== e_rdy) $display("FAIL crd_in_vld[%0d]: got %b expected %b", n, fifo_in_vld[1], e_rdy); else n_pass++;
         if (n < 4) sb_q.push_back({2'd1, wr_data[1]});
         cyc();
      end
      #1;
      n_chk++; if (dn_vld !== 1'b1) $display("FAIL crd_stage_full: got %b expected 1", dn_vld); else n_pass++;
      n_chk++; if (cnt[1] !== 3'd4) $display("FAIL crd_fifo_depth: got %0d expected 4", cnt[1]); else n_pass++;
      n_chk++; if (up_rdy[1] !== 1'b0) $display("FAIL crd_still_full: got %b expected 0", up_rdy[1]); else n_pass++;
      dn_rdy = 1'b1; #1;
      n_chk++; if (fifo_pick_rdy !== 4'b0010) $display("FAIL crd_pick: got %b expected 0010", fifo_pick_rdy); else n_pass++;
      n_chk++; if (up_rdy[1] !== 1'b0) $display("FAIL crd_same_cycle_rdy: got %b expected 0", up_rdy[1]); else n_pass++;
      n_chk++; if (fifo_in_vld[1] !== 1'b0) $display("FAIL crd_same_cycle_wr: got %b expected 0", fifo_in_vld[1]); else n_pass++;
      for (int c = 0; c < 14; c++) begin
         if (c == 1) begin
            n_chk++; if (up_rdy[1] !== 1'b1) $display("FAIL crd_return: got %b expected 1", up_rdy[1]); else n_pass++;
         end
         if (dn_vld && dn_rdy) begin
            n_chk++;
            if (sb_q.size() == 0) $display("FAIL crd_sb: unexpected src=%0d data=%h", dn_src, dn_data);
            else begin
               exp = sb_q.pop_front();
               if ({dn_src, dn_data} !== exp)
                  $display("FAIL crd_sb: got src=%0d data=%h expected src=%0d data=%h", dn_src, dn_data, exp[33:32], exp[31:0]);
               else n_pass++;
            end
         end
         cyc(); up_vld = 4'b0000; #1;
      end
      n_chk++; if (sb_q.size() !== 0) $display("FAIL crd_drain: got %0d left expected 0", sb_q.size()); else n_pass++;
   endtask

   task automatic test_stall();
      logic [33:0] exp;
      logic [33:0] held;
      int got, first, last;
      got = 0; first = -1; last = -1;
      apply_reset(); dn_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc(); up_vld = 4'b1111;
         for (int i = 0; i < REQ_NUM; i++) begin
            wr_data[i] = 32'h2000_0000 + 32'(i * 256 + k);
            sb_q.push_back({REQ_W'(i), wr_data[i]});
         end
         #1;
      end
      cyc(); up_vld = 4'b0000; #1;
      held = {2'd0, 32'h2000_0000};
      for (int c = 0; c < 10; c++) begin
         n_chk++; if (dn_vld !== 1'b1) $display("FAIL stall_vld[%0d]: got %b expected 1", c, dn_vld); else n_pass++;
         n_chk++; if ({dn_src, dn_data} !== held) $display("FAIL stall_hold[%0d]: got %h expected %h", c, {dn_src, dn_data}, held); else n_pass++;
         n_chk++; if (fifo_pick_rdy !== 4'b0000) $display("FAIL stall_pick[%0d]: got %b expected 0000", c, fifo_pick_rdy); else n_pass++;
         cyc(); #1;
      end
      dn_rdy = 1'b1; #1;
      for (int c = 0; c < 20; c++) begin
         if (dn_vld && dn_rdy) begin
            n_chk++; got++; if (first < 0) first = c; last = c;
            if (sb_q.size() == 0) $display("FAIL stall_sb: unexpected src=%0d data=%h", dn_src, dn_data);
            else begin
               exp = sb_q.pop_front();
               if ({dn_src, dn_data} !== exp)
                  $display("FAIL stall_sb: got src=%0d data=%h expected src=%0d data=%h", dn_src, dn_data, exp[33:32], exp[31:0]);
               else n_pass++;
            end
         end
         cyc(); #1;
      end
      n_chk++; if (got !== 8) $display("FAIL stall_count: got %0d expected 8", got); else n_pass++;
      n_chk++; if (last - first !== 7) $display("FAIL stall_resume_rate: got span %0d expected 7", last - first); else n_pass++;
   endtask

   task automatic test_simul();
      logic [33:0] exp;
      apply_reset(); dn_rdy = 1'b1;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (c < 8) begin
            up_vld = 4'b1000; wr_data[3] = 32'h0000_0300 + 32'(c);
            sb_q.push_back({2'd3, wr_data[3]});
         end else begin
            up_vld = 4'b0000;
         end
         #1;
         if (c >= 1 && c < 8) begin
            n_chk++; if (fifo_in_vld !== 4'b1000) $display("FAIL simul_in_vld[%0d]: got %b expected 1000", c, fifo_in_vld); else n_pass++;
            n_chk++; if (fifo_pick_rdy !== 4'b1000) $display("FAIL simul_pick[%0d]: got %b expected 1000", c, fifo_pick_rdy); else n_pass++;
            n_chk++; if (dut.r_crd[3] !== 3'd3) $display("FAIL simul_crd[%0d]: got %0d expected 3", c, dut.r_crd[3]); else n_pass++;
         end
         if (dn_vld && dn_rdy) begin
            n_chk++;
            if (sb_q.size() == 0) $display("FAIL simul_sb: unexpected src=%0d data=%h", dn_src, dn_data);
            else begin
               exp = sb_q.pop_front();
               if ({dn_src, dn_data} !== exp)
                  $display("FAIL simul_sb: got src=%0d data=%h expected src=%0d data=%h", dn_src, dn_data, exp[33:32], exp[31:0]);
               else n_pass++;
            end
         end
      end
      n_chk++; if (sb_q.size() !== 0) $display("FAIL simul_drain: got %0d left expected 0", sb_q.size()); else n_pass++;
      n_chk++; if (dut.r_crd[3] !== 3'd4) $display("FAIL simul_crd_final: got %0d expected 4", dut.r_crd[3]); else n_pass++;
   endtask

   task automatic test_mid_reset();
      apply_reset(); dn_rdy = 1'b0;
      cyc(); up_vld = 4'b1111;
      for (int i = 0; i < REQ_NUM; i++) wr_data[i] = 32'h4000_0000 + 32'(i);
      #1;
      cyc(); #1;
      cyc(); up_vld = 4'b0000; #1;
      n_chk++; if (dn_vld !== 1'b1) $display("FAIL mrst_pre_vld: got %b expected 1", dn_vld); else n_pass++;
      rst_n = 1'b0; #1;
      n_chk++; if (dn_vld !== 1'b0) $display("FAIL mrst_dn_vld: got %b expected 0", dn_vld); else n_pass++;
      n_chk++; if (dn_data !== 32'h0) $display("FAIL mrst_dn_data: got %h expected 0", dn_data); else n_pass++;
      n_chk++; if (dn_src !== 2'd0) $display("FAIL mrst_dn_src: got %0d expected 0", dn_src); else n_pass++;
      n_chk++; if (up_rdy !== 4'b1111) $display("FAIL mrst_up_rdy: got %b expected 1111", up_rdy); else n_pass++;
      n_chk++; if (fifo_pick_rdy !== 4'b0000) $display("FAIL mrst_pick: got %b expected 0000", fifo_pick_rdy); else n_pass++;
      cyc(); rst_n = 1'b1;
      cyc(); up_vld = 4'b0010; wr_data[1] = 32'h0000_BEEF; dn_rdy = 1'b1; #1;
      n_chk++; if (fifo_in_vld !== 4'b0010) $display("FAIL mrst_in_vld: got %b expected 0010", fifo_in_vld); else n_pass++;
      cyc(); up_vld = 4'b0000; #1;
      n_chk++; if (fifo_pick_rdy !== 4'b0010) $display("FAIL mrst_pick2: got %b expected 0010", fifo_pick_rdy); else n_pass++;
      cyc(); #1;
      n_chk++; if (dn_vld !== 1'b1) $display("FAIL mrst_out_vld: got %b expected 1", dn_vld); else n_pass++;
      n_chk++; if (dn_data !== 32'h0000_BEEF) $display("FAIL mrst_out_data: got %h expected 0000beef", dn_data); else n_pass++;
      n_chk++; if (dn_src !== 2'd1) $display("FAIL mrst_out_src: got %0d expected 1", dn_src); else n_pass++;
   endtask

   task automatic test_invariants();
      n_chk++; if (viol !== 0) $display("FAIL invariants: got %0d violations expected 0", viol); else n_pass++;
   endtask

   initial begin
      up_vld = 4'b0000; dn_rdy = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) wr_data[i] = 32'h0;
      test_reset();
      test_single();
      test_round_robin();
      test_credit_exhaust();
      test_stall();
      test_simul();
      test_mid_reset();
      test_invariants();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
